// File: rtl/sonido.sv
`default_nettype none
// ============================================================================
// Module   : sonido
// Purpose  : I2S stereo DAC driver (MCLK/LRCLK/SDIN) fed by a square-wave tone.
//            Optional macro SONIDO_MUTE_EN adds a frame-synchronous mute input.
// Revision : 1.0 - initial release
// ============================================================================
module sonido #(
    parameter int          TONE_HALF_PERIOD = 111,
    parameter logic [15:0] AMPLITUDE        = 16'h2000
) (
    input  logic clk,
    input  logic reset,
`ifdef SONIDO_MUTE_EN
    input  logic mute,
`endif
    output logic MCLK,
    output logic LRCLK,
    output logic SDIN
);

    localparam logic [11:0] FC_LAST       = 12'(TONE_HALF_PERIOD - 1);
    localparam logic [15:0] NEG_AMPLITUDE = 16'(~AMPLITUDE + 16'd1);

    logic [9:0]  cnt;
    logic [11:0] fc;
    logic        pol;
    logic [15:0] sample;
    logic        sdin_q;

    logic [9:0]  cnt_next;
    logic        wrap;
    logic        fc_last;
    logic        pol_next;
    logic        mute_now;
    logic [15:0] sample_next;
    logic [4:0]  slot_next;
    logic [3:0]  bit_idx;
    logic        sdin_next;

`ifdef SONIDO_MUTE_EN
    assign mute_now = mute;
`else
    assign mute_now = 1'b0;
`endif

    always_comb begin
        cnt_next    = cnt + 10'd1;
        wrap        = (cnt == 10'd1023);
        fc_last     = (fc == FC_LAST);
        pol_next    = fc_last ? ~pol : pol;
        sample_next = mute_now ? 16'h0000 : (pol_next ? NEG_AMPLITUDE : AMPLITUDE);
        // SDIN is registered from the next count so it switches cleanly on the
        // SCLK falling edge; slot s (1..16) carries sample bit 16-s.
        slot_next   = cnt_next[8:4];
        bit_idx     = 4'd0 - slot_next[3:0];
        sdin_next   = 1'b0;
        if ((slot_next != 5'd0) && (slot_next <= 5'd16)) begin
            sdin_next = sample[bit_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= 10'd0;
            fc     <= 12'd0;
            pol    <= 1'b0;
            sample <= AMPLITUDE;
            sdin_q <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            sdin_q <= sdin_next;
            if (wrap) begin
                pol    <= pol_next;
                fc     <= fc_last ? 12'd0 : fc + 12'd1;
                sample <= sample_next;
            end
        end
    end

    assign MCLK  = cnt[1];
    assign LRCLK = cnt[9];
    assign SDIN  = sdin_q;

endmodule
`default_nettype wire

// File: tb/tb_sonido.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonido
// Purpose  : Self-checking bench for sonido against a frame-level audio model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sonido;

    localparam int          THP = 2;
    localparam logic [15:0] AMP = 16'h2000;
    localparam logic [15:0] NEG = 16'hE000;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic mute  = 1'b0;
    logic MCLK, LRCLK, SDIN;

    int          checks = 0;
    int          errors = 0;
    int          n      = 0;
    logic [31:0] mute_mask = '0;
    logic [31:0] w;

    always #5 clk = ~clk;

    sonido #(
        .TONE_HALF_PERIOD (THP),
        .AMPLITUDE        (AMP)
    ) dut (
        .clk   (clk),
        .reset (reset),
`ifdef SONIDO_MUTE_EN
        .mute  (mute),
`endif
        .MCLK  (MCLK),
        .LRCLK (LRCLK),
        .SDIN  (SDIN)
    );

    // Edges since reset release, plus which frames were requested muted.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n         <= 0;
            mute_mask <= '0;
        end else begin
`ifdef SONIDO_MUTE_EN
            if (n % 1024 == 1023) mute_mask[(n / 1024 + 1) % 32] <= mute;
`endif
            n <= n + 1;
        end
    end

    function automatic logic exp_sdin(input int nn, input logic [31:0] mm);
        int          pos  = nn % 512;
        int          slot = pos / 16;
        int          k    = nn / 1024;
        logic [15:0] smp;
        if (slot < 1 || slot > 16) return 1'b0;
        if (mm[k % 32]) smp = 16'h0000;
        else            smp = ((k / THP) % 2 == 0) ? AMP : NEG;
        return smp[16 - slot];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got %h, expected %h", name, n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("mclk",  {31'd0, MCLK},  {31'd0, 1'((n / 2) % 2)});
        chk("lrclk", {31'd0, LRCLK}, {31'd0, 1'(((n % 1024) / 512) % 2)});
        chk("sdin",  {31'd0, SDIN},  {31'd0, exp_sdin(n, mute_mask)});
    end

    task automatic wait_n(input int target);
        int guard = 0;
        while (n != target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (n != target) chk("wait_timeout", n, target);
    endtask

    // Sample SDIN at each SCLK rising edge of one channel half, MSB first.
    task automatic capture(input int base, output logic [31:0] word);
        word = '0;
        for (int s = 0; s < 32; s++) begin
            wait_n(base + s * 16 + 8);
            word = {word[30:0], SDIN};
        end
    endtask

    initial begin
        #20;
        @(negedge clk);
        chk("rst_mclk",  {31'd0, MCLK},  32'd0);
        chk("rst_lrclk", {31'd0, LRCLK}, 32'd0);
        chk("rst_sdin",  {31'd0, SDIN},  32'd0);
        reset = 1'b1;

        wait_n(1);    chk("mclk_e1", {31'd0, MCLK}, 32'd0);
        wait_n(2);    chk("mclk_e2", {31'd0, MCLK}, 32'd1);
        capture(0, w);    chk("f0_left", w, 32'h1000_0000);
        wait_n(511);  chk("lr_511",  {31'd0, LRCLK}, 32'd0);
        wait_n(512);  chk("lr_512",  {31'd0, LRCLK}, 32'd1);
        capture(512, w);  chk("f0_right", w, 32'h1000_0000);
        wait_n(1023); chk("lr_1023", {31'd0, LRCLK}, 32'd1);
        wait_n(1024); chk("lr_1024", {31'd0, LRCLK}, 32'd0);
        capture(1024, w); chk("f1_left", w, 32'h1000_0000);
        capture(2048, w); chk("f2_left", w, 32'h7000_0000);
        capture(3072, w); chk("f3_left", w, 32'h7000_0000);
        capture(4096, w); chk("f4_left", w, 32'h1000_0000);

        wait_n(5 * 1024 + 700);
        #2 reset = 1'b0;
        #1;
        chk("midrst_mclk",  {31'd0, MCLK},  32'd0);
        chk("midrst_lrclk", {31'd0, LRCLK}, 32'd0);
        chk("midrst_sdin",  {31'd0, SDIN},  32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        capture(0, w);    chk("rs_f0_left", w, 32'h1000_0000);
        capture(2048, w); chk("rs_f2_left", w, 32'h7000_0000);
        wait_n(3 * 1024 + 100);
`ifdef SONIDO_MUTE_EN
        mute = 1'b1;
`endif
        capture(4096, w);
`ifdef SONIDO_MUTE_EN
        chk("mute_f4", w, 32'h0000_0000);
        mute = 1'b0;
`else
        chk("rs_f4_left", w, 32'h1000_0000);
`endif
        capture(5120, w); chk("rs_f5_left", w, 32'h1000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sonido.md
Name: sonido

Overview:
- Audio output block driving an external I2S stereo DAC (CS4344-class, internal-SCLK mode) from the 100 MHz system clock.
- Generates MCLK, LRCLK and serial data SDIN.
- The sample source is a built-in square-wave tone generator, sent identically to both channels.
- Sits at the top level next to the game logic, as the sound back end.

Parameters:
- TONE_HALF_PERIOD, 111, frames per tone half-cycle (111 gives about 440 Hz at Fs = 97.656 kHz); legal range 1..4095.
- AMPLITUDE, 16'h2000, positive sample magnitude; the negative half-cycle sends its two's complement (16'hE000 at default).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- MCLK  output  1  DAC master clock, clk/4 (25 MHz).
- LRCLK  output  1  word select, clk/1024; 0 = left, 1 = right.
- SDIN  output  1  I2S serial data, MSB first.

Behaviour:
- Timebase is a 10-bit free-running counter cnt.
  - Async clear to 0 while reset = 0.
  - Otherwise increments every clk rising edge and wraps 1023 -> 0.
  - One frame = 1024 clk.
- Output mapping:
  - MCLK = cnt[1] (50% duty, period 4 clk).
  - LRCLK = cnt[9] (low for 512 clk, then high for 512 clk).
  - Internal bit clock SCLK = cnt[3] (64 x Fs, period 16 clk). Data changes when cnt[3:0] == 0, i.e. the SCLK falling edge; the DAC samples at the rising edge (cnt[3:0] == 8).
- Slots: slot = cnt[8:4] (0..31) within each channel half.
  - slot 0: SDIN = 0 (I2S one-bit delay).
  - slots 1..16: SDIN = sample[16 - slot] (MSB at slot 1, LSB at slot 16).
  - slots 17..31: SDIN = 0.
- Reset values: cnt = 0, MCLK = 0, LRCLK = 0, SDIN = 0.
- All outputs are decoded from registers only, with single-bit or registered decode, so there are no glitches.
- Sample register (16 bit):
  - Reset value is +AMPLITUDE.
  - A new value loads on the edge where cnt wraps 1023 -> 0.
  - It is held constant for the whole frame, and the same value is sent to left and right.
- Tone generator:
  - State is a 12-bit frame counter fc (reset 0) and a polarity bit pol (reset 0 = positive).
  - On each wrap: if fc == TONE_HALF_PERIOD-1, then fc <= 0 and pol toggles; else fc increments.
  - The sample loaded is +AMPLITUDE if the new pol = 0, else -AMPLITUDE.
  - Net effect: frame k (counting from 0 after reset) carries +AMPLITUDE when floor(k / TONE_HALF_PERIOD) is even, otherwise -AMPLITUDE.
- TONE_HALF_PERIOD = 1: polarity toggles every frame.
- Reset asserted mid-frame:
  - Immediate asynchronous return to all reset values.
  - The restart after release is identical to power-up; no partial frame is resumed.
- Latency after reset release:
  - The first MCLK rise occurs at the 2nd clk edge.
  - The first LRCLK rise occurs at the 512th edge.
  - The MSB of the left sample is driven from edge 16 through edge 31.

Optional Feature:
- SONIDO_MUTE_EN defined:
  - Adds input port mute (1 bit, synchronous, sampled at the frame wrap).
  - If mute = 1 at the wrap, the loaded sample is 16'h0000 for that frame.
  - The tone generator keeps running, so unmuting resumes at the correct phase.
  - MCLK and LRCLK are unaffected.
- SONIDO_MUTE_EN undefined:
  - No mute port exists.
  - Tone samples are always output.

Test Plan:
- Reset: hold reset = 0 for 20 ns at 100 MHz -> MCLK, LRCLK and SDIN all 0 during reset; after release, MCLK toggles every 2 clk (period 40 ns).
- LRCLK timing -> low for 5120 ns, high for 5120 ns, period 10.24 us; edges coincide with cnt wrap and cnt = 512.
- Serial frame, frame 0 at defaults -> sampling SDIN at each cnt[3:0] == 8 gives left bits 0, 0010_0000_0000_0000, then 15 zeros; the right half is identical.
- Polarity toggle with TONE_HALF_PERIOD = 2 -> frames 0,1 carry 16'h2000; frames 2,3 carry 16'hE000; frame 4 carries 16'h2000.
- Mid-frame reset at cnt = 700 -> outputs are 0 immediately; after release, frame 0 restarts with +AMPLITUDE and fc = 0.
- With SONIDO_MUTE_EN, set mute = 1 during frame 3 -> frame 4 data is all zeros, MCLK and LRCLK unchanged; with mute = 0 at the next wrap, frame 5 carries the tone value for k = 5.
